// File: rtl/uart_boot_loader.sv
// UART serial image loader driving RAM port B.
// Holds the CPU in reset until a header-described image is written.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [ADDR_WIDTH-1:0] memAddrB,
  output logic [15:0]           memDataB,
  output logic                  memWeB,
  output logic                  cpuHold,
  output logic                  loadDone,
  output logic                  frameErr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    L_HDR_ADDR, L_HDR_COUNT, L_DATA, L_DONE
  } ld_state_t;

  logic          rx_meta;
  logic          rx_sync;
  rx_state_t     rs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_bad;

  ld_state_t     ls;
  logic          hi_pending;
  logic [7:0]    hi_byte;
  logic [15:0]   remaining;
  logic [15:0]   word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs         <= R_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_bad  <= 1'b0;
      frameErr   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_bad  <= 1'b0;
      unique case (rs)
        R_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_sync) rs <= R_START;
        end
        R_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            rs  <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rs <= R_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            rs  <= R_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frameErr  <= 1'b1;
              frame_bad <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign word = {hi_byte, byte_data};

  // Address advance happens the edge after the write pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ls         <= L_HDR_ADDR;
      hi_pending <= 1'b0;
      hi_byte    <= '0;
      remaining  <= '0;
      memAddrB   <= '0;
      memDataB   <= '0;
      memWeB     <= 1'b0;
      cpuHold    <= 1'b1;
      loadDone   <= 1'b0;
    end else begin
      memWeB <= 1'b0;
      if (memWeB) begin
        memAddrB  <= memAddrB + 1'b1;
        remaining <= remaining - 1'b1;
        if (remaining == 16'd1) begin
          ls       <= L_DONE;
          cpuHold  <= 1'b0;
          loadDone <= 1'b1;
        end
      end
      if (frame_bad) begin
        hi_pending <= 1'b0;
      end else if (byte_valid) begin
        if (!hi_pending) begin
          hi_byte    <= byte_data;
          hi_pending <= 1'b1;
        end else begin
          hi_pending <= 1'b0;
          unique case (ls)
            L_HDR_ADDR: begin
              memAddrB <= word[ADDR_WIDTH-1:0];
              ls       <= L_HDR_COUNT;
            end
            L_HDR_COUNT: begin
              if (word == 16'd0) begin
                ls       <= L_DONE;
                cpuHold  <= 1'b0;
                loadDone <= 1'b1;
              end else begin
                remaining <= word;
                ls        <= L_DATA;
              end
            end
            L_DATA: begin
              memDataB <= word;
              memWeB   <= 1'b1;
            end
            L_DONE: begin
              hi_byte <= hi_byte;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Serial program loader that owns port B of the CPU's dual-port instruction/data RAM. It receives a byte stream on a UART RX line, assembles it into 16-bit words and writes them into RAM through port B, holding the CPU in reset until the image is complete. The CPU fetches and executes on port A; this block is the writer on port B. It then releases the CPU to fetch from the freshly loaded memory.

## Interface
Parameters:
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- ADDR_WIDTH, 10: RAM word-address width, matching port B.

Ports:
- clk, input, 1: system clock; all logic is rising-edge.
- rst, input, 1: reset, asynchronous and active-high.
- rx, input, 1: UART receive line, idle high, 8N1, LSB first; asynchronous to clk.
- memAddrB, output, ADDR_WIDTH: RAM port B word address.
- memDataB, output, 16: RAM port B write data.
- memWeB, output, 1: RAM port B write enable, one-cycle pulse per word.
- cpuHold, output, 1: held high while loading; the top level ORs it into the CPU reset.
- loadDone, output, 1: high once the full image is written.
- frameErr, output, 1: sticky flag, set on any stop-bit error.

## Operation
- **Synchronizer:** rx passes through a 2-flop synchronizer whose flops reset to 1. All receiver logic uses the synchronized value.
- **Receiver FSM:** states IDLE, START, DATA, STOP.
  - IDLE → START on synchronized rx = 0.
  - START: wait CLKS_PER_BIT/2 cycles (integer divide), then sample. If low, go to DATA. If high, it was a glitch: return to IDLE with no byte.
  - DATA: sample every CLKS_PER_BIT cycles. 8 samples are shifted in LSB first; bit counter runs 0..7, then STOP.
  - STOP: after CLKS_PER_BIT cycles, sample. If high, pulse byteValid for 1 cycle with the byte. If low, set frameErr and drop the byte. Either way return to IDLE.
- **Word assembly:** bytes pair big-endian (first byte = bits 15:8). A hiPending flag marks a held high byte. A framing error clears hiPending, so the pair restarts.
- **Loader FSM:** states HDR_ADDR, HDR_COUNT, DATA, DONE.
  - HDR_ADDR: the first word gives the start address from bits [ADDR_WIDTH-1:0]; upper bits are ignored.
  - HDR_COUNT: the second word is the 16-bit word count N. N = 0 goes straight to DONE; otherwise go to DATA.
  - DATA: each word writes at the current address. After the write, the address increments modulo 2^ADDR_WIDTH (wraps 1023 → 0) and the remaining count decrements. After the Nth write, go to DONE.
  - DONE: cpuHold = 0 and loadDone = 1. All further rx traffic is received but ignored: no writes, and frameErr still updates.
- Only DATA state produces memWeB. Header words never write RAM.
- **Reset mid-operation:** every state returns to IDLE / HDR_ADDR and hiPending clears. RAM contents are not touched; partial images remain.

## Timing
- **Reset values:** memAddrB = 0, memDataB = 0, memWeB = 0, cpuHold = 1, loadDone = 0, frameErr = 0.
- **rx latency:** 2 clk from pin to the synchronized value.
- **Start-bit confirmation:** CLKS_PER_BIT/2 cycles after the synchronized falling edge.
- **Data sampling:** bit k is sampled at CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT cycles after the edge. The stop bit is sampled at + 9·CLKS_PER_BIT.
- **Write timing:** memWeB is high exactly in the cycle after the low-byte byteValid. memAddrB and memDataB are stable and registered in that same cycle. memAddrB advances on the following edge.
- **Release timing:** cpuHold falls and loadDone rises in the cycle after the final memWeB pulse. For N = 0, this happens the cycle after the count word's byteValid.
- **Write rate:** back-to-back bytes give at most one write per 20·CLKS_PER_BIT cycles, so there is no port-B contention within the block.
- The CPU never writes port B; port A/B same-address collisions are impossible while cpuHold = 1.

## Test plan
All scenarios use CLKS_PER_BIT = 8.
1. **Reset:** assert rst mid-byte → all outputs at reset values asynchronously. After release, a fresh header is required.
2. **Basic load:** send bytes 00 10 00 03 12 34 AB CD 00 07 → three memWeB pulses writing addr 0x010 = 0x1234, 0x011 = 0xABCD, 0x012 = 0x0007. cpuHold falls and loadDone rises the cycle after the third pulse.
3. **Address wrap:** header addr 0x3FF, count 2, data 1111 2222 → writes 0x3FF = 0x1111, then 0x000 = 0x2222.
4. **Zero count:** send 00 05 00 00 → no memWeB; loadDone = 1 the cycle after the fourth byteValid.
5. **Framing error:**
   - During DATA, send 0x12 then a byte with stop bit = 0 → frameErr = 1, no write, hiPending cleared.
   - Next send 56 78 → writes 0x5678 at the expected address.
6. **Glitch and post-DONE traffic:**
   - A 2-cycle low pulse on rx → no byte received.
   - After DONE, send 4 valid bytes → no memWeB, and cpuHold stays 0.
